// File: rtl/cond_exec_unit_if.sv
// cond_exec_unit_if: decode-side control, ALU flags and gated execute-side outputs of the condition unit.
interface cond_exec_unit_if;
  logic       StallE;
  logic       FlushE;
  logic [3:0] CondD;
  logic [1:0] FlagWD;
  logic       RegWriteD;
  logic       MemWriteD;
  logic       MemToRegD;
  logic       BranchD;
  logic       PCSrcD;
  logic [3:0] ALUFlagsE;
  logic       RegWriteE;
  logic       MemWriteE;
  logic       MemToRegE;
  logic       BranchTakenE;
  logic       PCSrcE;
  logic       CondExE;
  logic [3:0] FlagsQ;
  modport master (
    output StallE, FlushE, CondD, FlagWD, RegWriteD, MemWriteD, MemToRegD, BranchD, PCSrcD, ALUFlagsE,
    input  RegWriteE, MemWriteE, MemToRegE, BranchTakenE, PCSrcE, CondExE, FlagsQ
  );
  modport slave (
    input  StallE, FlushE, CondD, FlagWD, RegWriteD, MemWriteD, MemToRegD, BranchD, PCSrcD, ALUFlagsE,
    output RegWriteE, MemWriteE, MemToRegE, BranchTakenE, PCSrcE, CondExE, FlagsQ
  );
endinterface

// File: rtl/cond_exec_unit.sv
// cond_exec_unit: D->E control register, NZCV flag register and condition gating; COND_FULL_CODES_EN enables all 16 condition codes.
module cond_exec_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input logic             clk,
  input logic             reset,
  cond_exec_unit_if.slave bus
);
  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] flagw;
    logic       rw;
    logic       mw;
    logic       mtr;
    logic       br;
    logic       pcs;
  } de_t;
  localparam de_t BUBBLE = de_t'{4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  de_t        de_q, de_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex, n, z, c, v, upd;
  assign {n, z, c, v} = flags_q;
  always_comb begin
    cond_ex = 1'b0;
`ifdef COND_FULL_CODES_EN
    case (de_q.cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c & !z;
      4'b1001: cond_ex = !c | z;
      4'b1010: cond_ex = n == v;
      4'b1011: cond_ex = n != v;
      4'b1100: cond_ex = !z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
`else
    cond_ex = de_q.cond == 4'b0000 ? z : de_q.cond == 4'b0001 ? !z : de_q.cond == 4'b1110;
`endif
  end
  // Gating uses flags from before this instruction's own update.
  always_comb begin
    upd            = cond_ex & !bus.StallE;
    flags_d[3:2]   = (upd & de_q.flagw[1]) ? bus.ALUFlagsE[3:2] : flags_q[3:2];
    flags_d[1:0]   = (upd & de_q.flagw[0]) ? bus.ALUFlagsE[1:0] : flags_q[1:0];
    de_d           = bus.FlushE ? BUBBLE : bus.StallE ? de_q :
                     de_t'{bus.CondD, bus.FlagWD, bus.RegWriteD, bus.MemWriteD, bus.MemToRegD, bus.BranchD, bus.PCSrcD};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      de_q    <= BUBBLE;
      flags_q <= FLAG_RST;
    end else begin
      de_q    <= de_d;
      flags_q <= flags_d;
    end
  end
  assign bus.RegWriteE    = de_q.rw & cond_ex;
  assign bus.MemWriteE    = de_q.mw & cond_ex;
  assign bus.MemToRegE    = de_q.mtr;
  assign bus.BranchTakenE = de_q.br & cond_ex;
  assign bus.PCSrcE       = de_q.pcs & cond_ex;
  assign bus.CondExE      = cond_ex;
  assign bus.FlagsQ       = flags_q;
endmodule

// File: tb/tb_cond_exec_unit.sv
// tb_cond_exec_unit: vector table and hand sequences with hand-derived expectations, then random traffic against a reference model.
module tb_cond_exec_unit;
  logic clk = 1'b0;
  logic reset;
  cond_exec_unit_if bus ();
  cond_exec_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic       st, fl;
    logic [3:0] cond;
    logic [1:0] fw;
    logic       rw, mw, mtr, br, pcs;
    logic [3:0] alu;
    logic [9:0] exp;
  } vec_t;

  vec_t       vecs [17];
  logic [9:0] sb_q [$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] m_cond, m_flags;
  logic [1:0] m_flagw;
  logic       m_rw, m_mw, m_mtr, m_br, m_pcs;

`ifdef COND_FULL_CODES_EN
  localparam logic [9:0] V5_EXP = 10'b00011_1_1001;
`else
  localparam logic [9:0] V5_EXP = 10'b00000_0_1001;
`endif

  function automatic logic ref_pass(input logic [3:0] cc, input logic [3:0] f);
    logic nn, zz, cf, vv;
    {nn, zz, cf, vv} = f;
`ifdef COND_FULL_CODES_EN
    case (cc)
      4'h0: return zz;        4'h1: return ~zz;
      4'h2: return cf;        4'h3: return ~cf;
      4'h4: return nn;        4'h5: return ~nn;
      4'h6: return vv;        4'h7: return ~vv;
      4'h8: return cf && !zz; 4'h9: return !cf || zz;
      4'hA: return nn ~^ vv;  4'hB: return nn ^ vv;
      4'hC: return !zz && (nn ~^ vv);
      4'hD: return zz || (nn ^ vv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
`else
    if (cc == 4'h0) return zz;
    if (cc == 4'h1) return ~zz;
    return cc == 4'hE;
`endif
  endfunction

  function automatic logic [9:0] get_out();
    return {bus.RegWriteE, bus.MemWriteE, bus.MemToRegE, bus.BranchTakenE, bus.PCSrcE, bus.CondExE, bus.FlagsQ};
  endfunction

  task automatic drive(input logic st, input logic fl, input logic [3:0] cond, input logic [1:0] fw,
                       input logic rw, input logic mw, input logic mtr, input logic br, input logic pcs,
                       input logic [3:0] alu);
    bus.StallE = st;   bus.FlushE = fl;    bus.CondD = cond;   bus.FlagWD = fw;
    bus.RegWriteD = rw; bus.MemWriteD = mw; bus.MemToRegD = mtr; bus.BranchD = br;
    bus.PCSrcD = pcs;  bus.ALUFlagsE = alu;
  endtask

  task automatic step(input string nm);
    logic [9:0] e, a;
    @(posedge clk);
    #1;
    a = get_out();
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty got=%b", nm, a);
    end else begin
      e = sb_q.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL %s got {rw,mw,mtr,bt,pcs,cex,nzcv}=%b expected=%b", nm, a, e);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b00000_1_0000};
    vecs[1]  = '{1'b0, 1'b0, 4'b1110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b10000_1_0000};
    vecs[2]  = '{1'b0, 1'b0, 4'b0001, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 10'b00000_0_0100};
    vecs[3]  = '{1'b0, 1'b0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 10'b10100_1_0100};
    vecs[4]  = '{1'b0, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b00000_1_0100};
    vecs[5]  = '{1'b0, 1'b0, 4'b1010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1001, V5_EXP};
    vecs[6]  = '{1'b0, 1'b0, 4'b1011, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b00000_0_1001};
    vecs[7]  = '{1'b0, 1'b0, 4'b1110, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 10'b00000_1_1001};
    vecs[8]  = '{1'b0, 1'b0, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 10'b00000_0_1010};
    vecs[9]  = '{1'b0, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 10'b00000_1_1010};
    vecs[10] = '{1'b1, 1'b1, 4'b1110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 10'b00000_1_1010};
    vecs[11] = '{1'b0, 1'b0, 4'b1110, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b11000_1_1010};
    vecs[12] = '{1'b1, 1'b0, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 10'b11000_1_1010};
    vecs[13] = '{1'b1, 1'b0, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 10'b11000_1_1010};
    vecs[14] = '{1'b0, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 10'b00000_1_0101};
    vecs[15] = '{1'b0, 1'b0, 4'b1111, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b00000_0_0101};
    vecs[16] = '{1'b0, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 10'b00000_1_0101};

    reset = 1'b1;
    drive(1'b0, 1'b0, 4'b1110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
    @(posedge clk);
    sb_q.push_back(10'b00000_1_0000);
    step("reset_state");
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].fl, vecs[i].cond, vecs[i].fw, vecs[i].rw, vecs[i].mw,
            vecs[i].mtr, vecs[i].br, vecs[i].pcs, vecs[i].alu);
      sb_q.push_back(vecs[i].exp);
      step($sformatf("vec%0d", i));
    end

    drive(1'b0, 1'b0, 4'b1110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    sb_q.push_back(10'b10000_1_0101);
    step("pre_reset_load");
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'b1110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010);
    sb_q.push_back(10'b00000_1_0000);
    step("mid_reset_discard");
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    sb_q.push_back(10'b00000_1_0000);
    step("post_reset_idle");
    drive(1'b0, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    sb_q.push_back(10'b00000_1_0000);
    step("b2b_setter");
    drive(1'b0, 1'b0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    sb_q.push_back(10'b10000_1_0100);
    step("b2b_eq_sees_z");
    drive(1'b0, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    sb_q.push_back(10'b00000_0_0100);
    step("b2b_ne_blocked");

    {m_cond, m_flagw, m_rw, m_mw, m_mtr, m_br, m_pcs, m_flags} = {4'b0001, 2'b00, 5'b10000, 4'b0100};
    for (int k = 0; k < 300; k++) begin
      logic st, fl, p;
      logic [3:0] cond, alu;
      logic [1:0] fw;
      logic [4:0] ctl;
      st   = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 5) == 0);
      cond = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
      fw   = 2'($urandom_range(0, 3));
      ctl  = 5'($urandom_range(0, 31));
      alu  = 4'($urandom_range(0, 15));
      drive(st, fl, cond, fw, ctl[4], ctl[3], ctl[2], ctl[1], ctl[0], alu);
      p = ref_pass(m_cond, m_flags);
      if (!st && p && m_flagw[1]) m_flags[3:2] = alu[3:2];
      if (!st && p && m_flagw[0]) m_flags[1:0] = alu[1:0];
      if (fl) {m_cond, m_flagw, m_rw, m_mw, m_mtr, m_br, m_pcs} = {4'b1110, 7'b0};
      else if (!st) {m_cond, m_flagw, m_rw, m_mw, m_mtr, m_br, m_pcs} = {cond, fw, ctl};
      p = ref_pass(m_cond, m_flags);
      sb_q.push_back({m_rw & p, m_mw & p, m_mtr, m_br & p, m_pcs & p, p, m_flags});
      step($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
